// File: rtl/ram_if.sv
// ram_if: write/read request bus between a RAM driver (master) and the RAM (slave).
interface ram_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_enb;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_enb;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_done;
  logic                  access_err;
  modport master (
    output wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
    input  rd_data, rd_valid, init_done, access_err
  );
  modport slave (
    input  wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
    output rd_data, rd_valid, init_done, access_err
  );
endinterface

// File: rtl/ram_dp_core.sv
// ram_dp_core: dual-port RAM, zero-fill sweep after reset; RAM_WR_FIRST_EN selects write-first collisions.
module ram_dp_core #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic   clk,
  input logic   rst,
  ram_if.slave  bus
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data, rd_word, mem_din;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  rd_valid, init_done, access_err, mem_we;
  // the sweep owns the single write port until READY
  always_comb begin
    mem_we   = !rst && (state == CLEAR || bus.wr_enb);
    mem_addr = state == CLEAR ? clr_ptr : bus.wr_addr;
    mem_din  = state == CLEAR ? '0 : bus.wr_data;
  end
`ifdef RAM_WR_FIRST_EN
  assign rd_word = (bus.wr_enb && bus.wr_addr == bus.rd_addr) ? bus.wr_data : mem[bus.rd_addr];
`else
  assign rd_word = mem[bus.rd_addr];
`endif
  always_ff @(posedge clk)
    if (mem_we) mem[mem_addr] <= mem_din;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      init_done  <= 1'b0;
      access_err <= 1'b0;
    end else if (state == CLEAR) begin
      clr_ptr  <= clr_ptr + 1'b1;
      rd_valid <= 1'b0;
      if (bus.wr_enb || bus.rd_enb) access_err <= 1'b1;
      if (&clr_ptr) begin
        state     <= READY;
        init_done <= 1'b1;
      end
    end else begin
      rd_valid <= bus.rd_enb;
      if (bus.rd_enb) rd_data <= rd_word;
    end
  end
  assign bus.rd_data    = rd_data;
  assign bus.rd_valid   = rd_valid;
  assign bus.init_done  = init_done;
  assign bus.access_err = access_err;
endmodule
